// File: rtl/iq_rssi_cca.sv
// iq_rssi_cca: clear-channel assessment from the RSSI stream with hysteresis, busy qualification and idle hold-off.
// Define IQ_RSSI_CCA_PEAK_EN to track the peak RSSI of each busy period; otherwise rssi_peak is tied to 0.
module iq_rssi_cca #(
   parameter int unsigned IQ_DATA_WIDTH = 16,
   parameter int unsigned HOLD_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [IQ_DATA_WIDTH-1:0] iq_rssi,
   input  logic                     iq_rssi_valid,
   input  logic [IQ_DATA_WIDTH-1:0] rssi_th_high,
   input  logic [IQ_DATA_WIDTH-1:0] rssi_th_low,
   input  logic [HOLD_WIDTH-1:0]    busy_min_samples,
   input  logic [HOLD_WIDTH-1:0]    idle_hold_samples,
   input  logic                     force_busy,
   input  logic                     force_idle,
   output logic                     ch_idle,
   output logic                     busy_rise,
   output logic                     busy_fall,
   output logic [HOLD_WIDTH-1:0]    busy_duration,
   output logic [IQ_DATA_WIDTH-1:0] rssi_peak
);

   localparam int unsigned CW = HOLD_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_BUSY, S_RELEASE} state_t;

   state_t                state, state_nxt;
   logic [HOLD_WIDTH-1:0] cnt, cnt_nxt, cnt_sat;
   logic [CW-1:0]         cnt_inc;
   logic                  hi, lo;
   logic                  busy_cur, busy_nxt, rise_c, fall_c;

   assign hi = $signed(iq_rssi) >= $signed(rssi_th_high);
   assign lo = $signed(iq_rssi) <  $signed(rssi_th_low);

   // cnt+1 is compared one bit wider so a saturated counter never wraps below the target
   assign cnt_inc = CW'(cnt) + CW'(1);
   assign cnt_sat = (&cnt) ? cnt : cnt + HOLD_WIDTH'(1);

   assign busy_cur = (state == S_BUSY) || (state == S_RELEASE);
   assign busy_nxt = (state_nxt == S_BUSY) || (state_nxt == S_RELEASE);
   assign rise_c   = busy_nxt && !busy_cur;
   assign fall_c   = busy_cur && !busy_nxt;

   // next-state and qualification counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (force_busy) begin
         state_nxt = S_BUSY;
         cnt_nxt   = '0;
      end else if (force_idle) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end else if (iq_rssi_valid) begin
         unique case (state)
            S_IDLE: begin
               if (hi) begin
                  if (busy_min_samples <= HOLD_WIDTH'(1)) begin
                     state_nxt = S_BUSY;
                  end else begin
                     state_nxt = S_ARM;
                     cnt_nxt   = HOLD_WIDTH'(1);
                  end
               end
            end
            S_ARM: begin
               if (!hi) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
               end else if (cnt_inc >= CW'(busy_min_samples)) begin
                  state_nxt = S_BUSY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt   = cnt_sat;
               end
            end
            S_BUSY: begin
               if (lo) begin
                  if (idle_hold_samples <= HOLD_WIDTH'(1)) begin
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt = S_RELEASE;
                     cnt_nxt   = HOLD_WIDTH'(1);
                  end
               end
            end
            S_RELEASE: begin
               if (!lo) begin
                  state_nxt = S_BUSY;
                  cnt_nxt   = '0;
               end else if (cnt_inc >= CW'(idle_hold_samples)) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt   = cnt_sat;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= S_IDLE;
         cnt           <= '0;
         ch_idle       <= 1'b1;
         busy_rise     <= 1'b0;
         busy_fall     <= 1'b0;
         busy_duration <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ch_idle   <= !busy_nxt;
         busy_rise <= rise_c;
         busy_fall <= fall_c;
         if (rise_c) begin
            busy_duration <= HOLD_WIDTH'(1);
         end else if (busy_cur && iq_rssi_valid && !(&busy_duration)) begin
            busy_duration <= busy_duration + HOLD_WIDTH'(1);
         end
      end
   end

`ifdef IQ_RSSI_CCA_PEAK_EN
   // peak restarts at each busy entry and only follows valid samples while busy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rssi_peak <= '0;
      end else if (rise_c) begin
         rssi_peak <= iq_rssi;
      end else if (busy_cur && iq_rssi_valid && ($signed(iq_rssi) > $signed(rssi_peak))) begin
         rssi_peak <= iq_rssi;
      end
   end
`else
   assign rssi_peak = '0;
`endif

endmodule

// File: tb/tb_iq_rssi_cca.sv
// Self-checking bench for iq_rssi_cca: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a run-length model of the CCA rules.
module tb_iq_rssi_cca;

   localparam int unsigned DW = 16;
   localparam int unsigned HW = 6;
   localparam int DUR_MAX = (1 << HW) - 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] iq_rssi;
   logic          iq_rssi_valid;
   logic [DW-1:0] rssi_th_high;
   logic [DW-1:0] rssi_th_low;
   logic [HW-1:0] busy_min_samples;
   logic [HW-1:0] idle_hold_samples;
   logic          force_busy;
   logic          force_idle;
   logic          ch_idle;
   logic          busy_rise;
   logic          busy_fall;
   logic [HW-1:0] busy_duration;
   logic [DW-1:0] rssi_peak;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   iq_rssi_cca #(.IQ_DATA_WIDTH(DW), .HOLD_WIDTH(HW)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .iq_rssi           (iq_rssi),
      .iq_rssi_valid     (iq_rssi_valid),
      .rssi_th_high      (rssi_th_high),
      .rssi_th_low       (rssi_th_low),
      .busy_min_samples  (busy_min_samples),
      .idle_hold_samples (idle_hold_samples),
      .force_busy        (force_busy),
      .force_idle        (force_idle),
      .ch_idle           (ch_idle),
      .busy_rise         (busy_rise),
      .busy_fall         (busy_fall),
      .busy_duration     (busy_duration),
      .rssi_peak         (rssi_peak)
   );

   always #5 clk = ~clk;

   // Model: busy flag plus length of the current qualifying run.
   bit m_busy = 1'b0;
   int m_run  = 0;
   bit m_idle = 1'b1;
   bit m_rise = 1'b0;
   bit m_fall = 1'b0;
   int m_dur  = 0;
   int m_peak = 0;

   always @(posedge clk) begin
      bit was_busy;
      int s;
      s = int'($signed(iq_rssi));
      if (!rstn) begin
         m_busy = 1'b0; m_run = 0; m_idle = 1'b1;
         m_rise = 1'b0; m_fall = 1'b0; m_dur = 0; m_peak = 0;
      end else begin
         was_busy = m_busy;
         if (force_busy) begin
            m_busy = 1'b1; m_run = 0;
         end else if (force_idle) begin
            m_busy = 1'b0; m_run = 0;
         end else if (iq_rssi_valid) begin
            if (!m_busy) begin
               if (s >= int'($signed(rssi_th_high))) begin
                  m_run++;
                  if (m_run >= int'(busy_min_samples)) begin m_busy = 1'b1; m_run = 0; end
               end else m_run = 0;
            end else begin
               if (s < int'($signed(rssi_th_low))) begin
                  m_run++;
                  if (m_run >= int'(idle_hold_samples)) begin m_busy = 1'b0; m_run = 0; end
               end else m_run = 0;
            end
         end
         m_rise = m_busy && !was_busy;
         m_fall = was_busy && !m_busy;
         m_idle = !m_busy;
         if (m_rise) begin
            m_dur = 1;
`ifdef IQ_RSSI_CCA_PEAK_EN
            m_peak = s;
`endif
         end else if (was_busy && iq_rssi_valid) begin
            if (m_dur < DUR_MAX) m_dur++;
`ifdef IQ_RSSI_CCA_PEAK_EN
            if (s > m_peak) m_peak = s;
`endif
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model ch_idle",   int'(ch_idle),   int'(m_idle));
         check("model busy_rise", int'(busy_rise), int'(m_rise));
         check("model busy_fall", int'(busy_fall), int'(m_fall));
         check("model busy_dur",  int'(busy_duration), m_dur);
         check("model rssi_peak", int'($signed(rssi_peak)), m_peak);
      end
   end

   // Apply inputs at a falling edge; return at the next falling edge with the result visible.
   task automatic step(input bit v, input int val);
      iq_rssi       = DW'(val);
      iq_rssi_valid = v;
      @(negedge clk);
   endtask

   int exp_peak;

   initial begin
      rstn = 1'b0; iq_rssi = '0; iq_rssi_valid = 1'b0;
      rssi_th_high = DW'(100); rssi_th_low = DW'(60);
      busy_min_samples = HW'(4); idle_hold_samples = HW'(3);
      force_busy = 1'b0; force_idle = 1'b0;
      @(negedge clk);
      step(0, 0);
      step(0, 0);
      check("reset ch_idle",   int'(ch_idle), 1);
      check("reset busy_rise", int'(busy_rise), 0);
      check("reset busy_fall", int'(busy_fall), 0);
      check("reset busy_dur",  int'(busy_duration), 0);
      check("reset rssi_peak", int'(rssi_peak), 0);
      chk_en = 1'b1;
      rstn   = 1'b1;

      // Four samples over th_high qualify busy
      for (int i = 0; i < 3; i++) step(1, 120);
      check("arm ch_idle", int'(ch_idle), 1);
      step(1, 120);
      check("entry busy_rise", int'(busy_rise), 1);
      check("entry ch_idle",   int'(ch_idle), 0);
      check("entry busy_dur",  int'(busy_duration), 1);

      // Release interrupted by 70, then three trailing lows
      step(1, 50); step(1, 50); step(1, 70); step(1, 50); step(1, 50);
      check("release ch_idle", int'(ch_idle), 0);
      check("release no fall", int'(busy_fall), 0);
      step(1, 50);
`ifdef IQ_RSSI_CCA_PEAK_EN
      exp_peak = 120;
`else
      exp_peak = 0;
`endif
      check("exit busy_fall", int'(busy_fall), 1);
      check("exit ch_idle",   int'(ch_idle), 1);
      check("exit busy_dur",  int'(busy_duration), 7);
      check("exit rssi_peak", int'($signed(rssi_peak)), exp_peak);
      step(0, 0);
      check("hold busy_dur", int'(busy_duration), 7);
      check("hold no fall",  int'(busy_fall), 0);

      // Interrupted qualification never declares busy
      for (int i = 0; i < 7; i++) begin
         step(1, (i == 3) ? 50 : 120);
         check("interrupt ch_idle", int'(ch_idle), 1);
         check("interrupt no rise", int'(busy_rise), 0);
      end
      step(1, 50);

      // Both forces: busy wins, then force_idle alone drops it
      force_busy = 1'b1; force_idle = 1'b1;
      step(0, 50);
      check("force rise",    int'(busy_rise), 1);
      check("force ch_idle", int'(ch_idle), 0);
      check("force dur",     int'(busy_duration), 1);
      force_busy = 1'b0;
      step(0, 50);
      check("force fall",      int'(busy_fall), 1);
      check("force idle",      int'(ch_idle), 1);
      check("force dur hold",  int'(busy_duration), 1);
      force_idle = 1'b0;

      // Peak over a busy period entered on a single sample
      busy_min_samples = HW'(1);
      step(1, 120);
      check("peak entry rise", int'(busy_rise), 1);
      step(1, 300); step(1, 150); step(1, 50); step(1, 50); step(1, 50);
`ifdef IQ_RSSI_CCA_PEAK_EN
      exp_peak = 300;
`else
      exp_peak = 0;
`endif
      check("peak fall",  int'(busy_fall), 1);
      check("peak dur",   int'(busy_duration), 6);
      check("peak value", int'($signed(rssi_peak)), exp_peak);
      step(0, 0);
      check("peak held",  int'($signed(rssi_peak)), exp_peak);

      // Thresholds with th_low above th_high
      rssi_th_high = DW'(50); rssi_th_low = DW'(80);
      for (int i = 0; i < 40; i++) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 130)));

      // Randomized traffic with live threshold changes, forces and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            rssi_th_high      = DW'(int'($urandom_range(0, 300)) - 100);
            rssi_th_low       = DW'(int'($urandom_range(0, 300)) - 150);
            busy_min_samples  = HW'($urandom_range(0, 6));
            idle_hold_samples = HW'($urandom_range(0, 6));
         end
         force_busy = ($urandom_range(0, 99) < 2);
         force_idle = ($urandom_range(0, 99) < 3);
         rstn       = ($urandom_range(0, 499) != 0);
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, 600)) - 200);
      end
      force_busy = 1'b0; force_idle = 1'b0; rstn = 1'b1;

      // Long busy period drives busy_duration into saturation
      rssi_th_high = DW'(0); rssi_th_low = DW'(-1000);
      busy_min_samples = HW'(1); idle_hold_samples = HW'(3);
      for (int i = 0; i < 90; i++) step(1, 200);
      check("saturated dur",  int'(busy_duration), DUR_MAX);
      check("saturated busy", int'(ch_idle), 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
